// File: rtl/calc_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : calc_pkg
//  Purpose  : Shared types and constants for the keypad calculator controller
//  Revision : 1.0  initial release
// ============================================================================
package calc_pkg;

    // Controller states
    typedef enum logic [2:0] {
        S_A    = 3'd0,
        S_OP   = 3'd1,
        S_B    = 3'd2,
        S_CALC = 3'd3,
        S_RES  = 3'd4,
        S_ERR  = 3'd5
    } state_t;

    // Operator key codes
    localparam logic [1:0] OP_ADD = 2'd0;
    localparam logic [1:0] OP_SUB = 2'd1;
    localparam logic [1:0] OP_MUL = 2'd2;
    localparam logic [1:0] OP_CLR = 2'd3;

    // Default operand length and the largest value it can display
    localparam int DIGITS_DEF = 4;
    localparam int DIGITS_MAX = 10**DIGITS_DEF - 1;

    // Digit keys carry 0..9; codes 10..15 are not digits
    function automatic logic is_digit(input logic [3:0] v);
        return (v <= 4'd9);
    endfunction

endpackage
`default_nettype wire

// File: rtl/calc_ctrl_shift_add_mul.sv
`default_nettype none
// ============================================================================
//  Module   : shift_add_mul
//  Purpose  : Unsigned shift-add multiplier, W-cycle latency, start/done
//             handshake. The first partial product is added on the start
//             edge, so the product is complete and done pulses W cycles
//             after start.
//  Revision : 1.0  initial release
// ============================================================================
module shift_add_mul #(
    parameter int W = 14
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [W-1:0]     a,
    input  logic [W-1:0]     b,
    output logic             done,
    output logic [2*W-1:0]   product
);

    localparam int CW = $clog2(W);

    logic [2*W-1:0] r_a_sh;
    logic [2*W-1:0] r_prod;
    logic [W-1:0]   r_b_sh;
    logic [CW-1:0]  r_cnt;
    logic           r_run;
    logic           r_done;

    // One partial product per cycle: on start and then W-1 more iterations
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_a_sh <= '0;
            r_prod <= '0;
            r_b_sh <= '0;
            r_cnt  <= '0;
            r_run  <= 1'b0;
            r_done <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (start) begin
                r_a_sh <= {{W{1'b0}}, a} << 1;
                r_b_sh <= b >> 1;
                r_prod <= b[0] ? {{W{1'b0}}, a} : '0;
                r_cnt  <= CW'(1);
                r_run  <= 1'b1;
            end else if (r_run) begin
                if (r_b_sh[0]) begin
                    r_prod <= r_prod + r_a_sh;
                end
                r_a_sh <= r_a_sh << 1;
                r_b_sh <= r_b_sh >> 1;
                r_cnt  <= r_cnt + CW'(1);
                if (r_cnt == CW'(W-1)) begin
                    r_run  <= 1'b0;
                    r_done <= 1'b1;
                end
            end
        end
    end

    assign done    = r_done;
    assign product = r_prod;

endmodule
`default_nettype wire

// File: rtl/calc_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : calc_ctrl
//  Purpose  : Keypad calculator sequencer: operand entry, operator chaining,
//             add/sub in one cycle, multiply through shift_add_mul, display
//             selection and overflow error handling.
//  Revision : 1.0  initial release
// ============================================================================
import calc_pkg::*;

module calc_ctrl #(
    parameter int DIGITS = DIGITS_DEF,
    parameter int W      = $clog2(10**DIGITS)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          press,
    input  logic          is_num,
    input  logic          is_op,
    input  logic          is_eq,
    input  logic [3:0]    num_val,
    input  logic [1:0]    op_val,
    output logic [W-1:0]  disp_val,
    output logic          disp_neg,
    output logic          err,
    output logic          busy
);

    localparam int             c_max_int  = 10**DIGITS - 1;
    localparam logic [W+3:0]   c_max_push = (W+4)'(c_max_int);
    localparam logic [W+1:0]   c_max_acc  = (W+2)'(c_max_int);
    localparam logic [2*W-1:0] c_max_prod = (2*W)'(c_max_int);

    state_t              r_state, w_state_nx;
    logic signed [W+1:0] r_acc_a, w_acc_a_nx;
    logic [W-1:0]        r_acc_b, w_acc_b_nx;
    logic [1:0]          r_op, w_op_nx;
    logic [1:0]          r_op_pend, w_op_pend_nx;
    logic                r_ret_op, w_ret_op_nx;

    logic                w_take, w_eq, w_op, w_clr, w_opk, w_num;
    logic [W-1:0]        w_mag_a;
    logic [W+3:0]        w_push_a, w_push_b;
    logic signed [W+1:0] w_sum, w_dif, w_res, w_mul_res;
    logic [W+1:0]        w_prod_lo;
    logic                w_mul_start, w_mul_done;
    logic [2*W-1:0]      w_prod;

    function automatic logic [W+1:0] mag2(input logic signed [W+1:0] v);
        return v[W+1] ? (W+2)'(-v) : (W+2)'(v);
    endfunction

    function automatic logic [W+3:0] dig_push(input logic [W-1:0] x, input logic [3:0] d);
        return ({4'd0, x} * (W+4)'(10)) + {{W{1'b0}}, d};
    endfunction

    // Key decode: events only while idle, priority eq > op > num
    assign w_take = press && !busy;
    assign w_eq   = w_take && is_eq;
    assign w_op   = w_take && !is_eq && is_op;
    assign w_clr  = w_op && (op_val == OP_CLR);
    assign w_opk  = w_op && (op_val != OP_CLR);
    assign w_num  = w_take && !is_eq && !is_op && is_num && is_digit(num_val);

    assign w_mag_a   = W'(mag2(r_acc_a));
    assign w_push_a  = dig_push(w_mag_a, num_val);
    assign w_push_b  = dig_push(r_acc_b, num_val);
    assign w_sum     = r_acc_a + $signed({2'b00, r_acc_b});
    assign w_dif     = r_acc_a - $signed({2'b00, r_acc_b});
    assign w_res     = (r_op == OP_SUB) ? w_dif : w_sum;
    assign w_prod_lo = (W+2)'(w_prod);
    assign w_mul_res = r_acc_a[W+1] ? -$signed(w_prod_lo) : $signed(w_prod_lo);

    shift_add_mul #(.W(W)) u_mul (
        .clk     (clk),
        .reset   (reset),
        .start   (w_mul_start),
        .a       (w_mag_a),
        .b       (r_acc_b),
        .done    (w_mul_done),
        .product (w_prod)
    );

    // State and datapath registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= S_A;
            r_acc_a   <= '0;
            r_acc_b   <= '0;
            r_op      <= OP_ADD;
            r_op_pend <= OP_ADD;
            r_ret_op  <= 1'b0;
        end else begin
            r_state   <= w_state_nx;
            r_acc_a   <= w_acc_a_nx;
            r_acc_b   <= w_acc_b_nx;
            r_op      <= w_op_nx;
            r_op_pend <= w_op_pend_nx;
            r_ret_op  <= w_ret_op_nx;
        end
    end

    // Next-state and datapath update; clear overrides every state
    always_comb begin
        w_state_nx   = r_state;
        w_acc_a_nx   = r_acc_a;
        w_acc_b_nx   = r_acc_b;
        w_op_nx      = r_op;
        w_op_pend_nx = r_op_pend;
        w_ret_op_nx  = r_ret_op;
        w_mul_start  = 1'b0;
        if (w_clr) begin
            w_acc_a_nx = '0;
            w_acc_b_nx = '0;
            w_op_nx    = OP_ADD;
            w_state_nx = S_A;
        end else begin
            case (r_state)
                S_A: begin
                    if (w_eq) begin
                        w_state_nx = S_RES;
                    end else if (w_opk) begin
                        w_op_nx    = op_val;
                        w_state_nx = S_OP;
                    end else if (w_num && (w_push_a <= c_max_push)) begin
                        w_acc_a_nx = $signed((W+2)'(w_push_a));
                    end
                end
                S_OP: begin
                    if (w_opk) begin
                        w_op_nx = op_val;
                    end else if (w_num) begin
                        w_acc_b_nx = W'(num_val);
                        w_state_nx = S_B;
                    end
                end
                S_B: begin
                    if (w_eq || w_opk) begin
                        w_ret_op_nx  = w_opk && !w_eq;
                        if (w_opk && !w_eq) begin
                            w_op_pend_nx = op_val;
                        end
                        w_mul_start = (r_op == OP_MUL);
                        w_state_nx  = S_CALC;
                    end else if (w_num && (w_push_b <= c_max_push)) begin
                        w_acc_b_nx = W'(w_push_b);
                    end
                end
                S_CALC: begin
                    if (r_op != OP_MUL || w_mul_done) begin
                        w_acc_b_nx = '0;
                        if (r_op == OP_MUL ? (w_prod > c_max_prod) : (mag2(w_res) > c_max_acc)) begin
                            w_state_nx = S_ERR;
                        end else begin
                            w_acc_a_nx = (r_op == OP_MUL) ? w_mul_res : w_res;
                            if (r_ret_op) begin
                                w_op_nx    = r_op_pend;
                                w_state_nx = S_OP;
                            end else begin
                                w_state_nx = S_RES;
                            end
                        end
                    end
                end
                S_RES: begin
                    if (w_opk) begin
                        w_op_nx    = op_val;
                        w_state_nx = S_OP;
                    end else if (w_num) begin
                        w_acc_a_nx = $signed((W+2)'(num_val));
                        w_state_nx = S_A;
                    end
                end
                S_ERR: begin
                end
                default: begin
                    w_state_nx = S_A;
                end
            endcase
        end
    end

    // Display selection decoded from registered state
    always_comb begin
        disp_val = '0;
        disp_neg = 1'b0;
        case (r_state)
            S_B:     disp_val = r_acc_b;
            S_ERR:   disp_val = '0;
            default: begin
                disp_val = w_mag_a;
                disp_neg = r_acc_a[W+1];
            end
        endcase
    end

    assign err  = (r_state == S_ERR);
    assign busy = (r_state == S_CALC);

endmodule
`default_nettype wire

// File: tb/tb_calc_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_calc_ctrl
//  Purpose  : Self-checking bench for calc_ctrl with an expectation queue
//  Revision : 1.0  initial release
// ============================================================================
module tb_calc_ctrl;

    localparam int K_NUM = 0;
    localparam int K_OP  = 1;
    localparam int K_EQ  = 2;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        press = 1'b0;
    logic        is_num = 1'b0;
    logic        is_op = 1'b0;
    logic        is_eq = 1'b0;
    logic [3:0]  num_val = 4'd0;
    logic [1:0]  op_val = 2'd0;
    logic [13:0] disp_val;
    logic        disp_neg;
    logic        err;
    logic        busy;

    typedef struct {
        int val;
        int neg;
        int er;
        int bcyc;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   step     = 0;

    calc_ctrl u_dut (
        .clk      (clk),
        .reset    (reset),
        .press    (press),
        .is_num   (is_num),
        .is_op    (is_op),
        .is_eq    (is_eq),
        .num_val  (num_val),
        .op_val   (op_val),
        .disp_val (disp_val),
        .disp_neg (disp_neg),
        .err      (err),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int expv);
        n_checks++;
        if (got != expv) begin
            n_fail++;
            $display("FAIL %s step %0d: got %0d expected %0d", tag, step, got, expv);
        end
    endtask

    // Drive one key, measure busy length, then compare with the queued expectation.
    // With inj set, a clear key is pressed while busy; it must be lost.
    task automatic key(input int kind, input int v, input int ev, input int en,
                       input int ee, input int eb, input bit inj);
        exp_t e;
        int   nb;
        e.val = ev; e.neg = en; e.er = ee; e.bcyc = eb;
        exp_q.push_back(e);
        step++;
        @(negedge clk);
        press   = 1'b1;
        is_num  = (kind == K_NUM);
        is_op   = (kind == K_OP);
        is_eq   = (kind == K_EQ);
        num_val = 4'(v);
        op_val  = 2'(v);
        @(negedge clk);
        press = 1'b0; is_num = 1'b0; is_op = 1'b0; is_eq = 1'b0;
        nb = 0;
        while (busy && nb < 64) begin
            if (inj && nb == 3) begin
                press = 1'b1; is_op = 1'b1; op_val = 2'd3;
            end else begin
                press = 1'b0; is_op = 1'b0;
            end
            @(negedge clk);
            nb++;
        end
        press = 1'b0; is_op = 1'b0;
        e = exp_q.pop_front();
        chk("busy_cycles", nb, e.bcyc);
        chk("disp_val", int'(disp_val), e.val);
        chk("disp_neg", int'(disp_neg), e.neg);
        chk("err", int'(err), e.er);
    endtask

    initial begin
        int nb;
        reset = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("rst_disp_val", int'(disp_val), 0);
        chk("rst_disp_neg", int'(disp_neg), 0);
        chk("rst_err", int'(err), 0);
        chk("rst_busy", int'(busy), 0);

        // 12 + 34 = 46
        key(K_NUM, 1, 1, 0, 0, 0, 0);
        key(K_NUM, 2, 12, 0, 0, 0, 0);
        key(K_OP, 0, 12, 0, 0, 0, 0);
        key(K_NUM, 3, 3, 0, 0, 0, 0);
        key(K_NUM, 4, 34, 0, 0, 0, 0);
        key(K_EQ, 0, 46, 0, 0, 1, 0);

        // 5 - 9 = -4, then chain + 2 = -2
        key(K_NUM, 5, 5, 0, 0, 0, 0);
        key(K_OP, 1, 5, 0, 0, 0, 0);
        key(K_NUM, 9, 9, 0, 0, 0, 0);
        key(K_EQ, 0, 4, 1, 0, 1, 0);
        key(K_OP, 0, 4, 1, 0, 0, 0);
        key(K_NUM, 2, 2, 0, 0, 0, 0);
        key(K_EQ, 0, 2, 1, 0, 1, 0);

        // 123 * 45 = 5535, clear pressed during busy is lost
        key(K_NUM, 1, 1, 0, 0, 0, 0);
        key(K_NUM, 2, 12, 0, 0, 0, 0);
        key(K_NUM, 3, 123, 0, 0, 0, 0);
        key(K_OP, 2, 123, 0, 0, 0, 0);
        key(K_NUM, 4, 4, 0, 0, 0, 0);
        key(K_NUM, 5, 45, 0, 0, 0, 0);
        key(K_EQ, 0, 5535, 0, 0, 14, 1);

        // 9999 * 2 overflows; only clear leaves the error
        key(K_OP, 3, 0, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) begin
            key(K_NUM, 9, (i == 0) ? 9 : (i == 1) ? 99 : (i == 2) ? 999 : 9999, 0, 0, 0, 0);
        end
        key(K_OP, 2, 9999, 0, 0, 0, 0);
        key(K_NUM, 2, 2, 0, 0, 0, 0);
        key(K_EQ, 0, 0, 0, 1, 14, 0);
        key(K_NUM, 5, 0, 0, 1, 0, 0);
        key(K_EQ, 0, 0, 0, 1, 0, 0);
        key(K_OP, 0, 0, 0, 1, 0, 0);
        key(K_OP, 3, 0, 0, 0, 0, 0);
        key(K_NUM, 7, 7, 0, 0, 0, 0);
        key(K_OP, 3, 0, 0, 0, 0, 0);

        // Fifth digit dropped
        key(K_NUM, 1, 1, 0, 0, 0, 0);
        key(K_NUM, 2, 12, 0, 0, 0, 0);
        key(K_NUM, 3, 123, 0, 0, 0, 0);
        key(K_NUM, 4, 1234, 0, 0, 0, 0);
        key(K_NUM, 5, 1234, 0, 0, 0, 0);
        key(K_OP, 3, 0, 0, 0, 0, 0);

        // 7 + 3 + chains into S_OP; digit 11 ignored; result replaced by digit
        key(K_NUM, 7, 7, 0, 0, 0, 0);
        key(K_OP, 0, 7, 0, 0, 0, 0);
        key(K_NUM, 3, 3, 0, 0, 0, 0);
        key(K_OP, 0, 10, 0, 0, 1, 0);
        key(K_NUM, 4, 4, 0, 0, 0, 0);
        key(K_NUM, 11, 4, 0, 0, 0, 0);
        key(K_EQ, 0, 14, 0, 0, 1, 0);
        key(K_NUM, 2, 2, 0, 0, 0, 0);

        // Reset in the middle of a multiply
        key(K_OP, 2, 2, 0, 0, 0, 0);
        key(K_NUM, 3, 3, 0, 0, 0, 0);
        step++;
        @(negedge clk);
        press = 1'b1; is_eq = 1'b1;
        @(negedge clk);
        press = 1'b0; is_eq = 1'b0;
        chk("mul_busy", int'(busy), 1);
        repeat (4) @(negedge clk);
        reset = 1'b0;
        #1;
        chk("midrst_disp_val", int'(disp_val), 0);
        chk("midrst_disp_neg", int'(disp_neg), 0);
        chk("midrst_err", int'(err), 0);
        chk("midrst_busy", int'(busy), 0);
        @(negedge clk);
        reset = 1'b1;
        nb = 0;
        repeat (20) begin
            @(negedge clk);
            if (busy) nb++;
        end
        chk("post_rst_busy", nb, 0);
        key(K_NUM, 8, 8, 0, 0, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/calc_ctrl.md
# calc_ctrl

Sequencing controller for the four-digit keypad calculator. Consumes the one-cycle key events from `keyb_iface` and collects decimal operands and an operator. On `=` or a chained operator it runs the arithmetic, with a multi-cycle shift-add multiply. It drives the value the display block shows, plus sign, error and busy flags.

## Interface
- `DIGITS`, default 4: maximum decimal digits per operand and result.
- `W`, default `$clog2(10**DIGITS)` (14): magnitude width.
- `clk` input, 1: rising-edge clock.
- `reset` input, 1: asynchronous, active-low; all state cleared while low.
- `press` input, 1: one-cycle key event strobe; qualifies the inputs below.
- `is_num` input, 1: event is a digit key.
- `is_op` input, 1: event is an operator key.
- `is_eq` input, 1: event is the `=` key.
- `num_val` input, 4: digit value; 10–15 ignored.
- `op_val` input, 2: 0 add, 1 sub, 2 mul, 3 clear.
- `disp_val` output, W: magnitude to display.
- `disp_neg` output, 1: displayed value is negative.
- `err` output, 1: overflow error latched.
- `busy` output, 1: computation in progress; key events dropped.

## Operation
- Registers:
  - `acc_a`: signed, W+2 bits.
  - `acc_b`: unsigned, W bits.
  - `op_r`: 2 bits.
  - `state`.
- Events are sampled only when `press`=1 and `busy`=0.
- Priority on simultaneous flags: `is_eq` > `is_op` > `is_num`.
- Digit accumulate: `x = x*10 + num_val`.
  - Applied only if the result is ≤ 10**DIGITS−1.
  - Otherwise the digit is silently dropped. No error is raised.
- Clear (`is_op`, `op_val`=3) applies in every state including ERR:
  - `acc_a`, `acc_b`, `op_r` and `err` go to 0.
  - Next state is S_A.
- States:
  - **S_A** (entering A):
    - digit → accumulate into `acc_a`.
    - op → `op_r`=op, next S_OP.
    - eq → S_RES, showing A.
  - **S_OP** (operator chosen, B empty):
    - digit → `acc_b`=digit, next S_B.
    - op → replace `op_r`.
    - eq → ignored.
  - **S_B** (entering B):
    - digit → accumulate into `acc_b`.
    - eq → S_CALC, with return target S_RES.
    - op → S_CALC, with return target S_OP. The new op is latched into a pending register and copied to `op_r` on exit.
  - **S_CALC**:
    - add: `acc_a += acc_b`, 1 cycle.
    - sub: `acc_a -= acc_b`, 1 cycle.
    - mul: shift-add of |A| by B over W cycles; result sign is the sign of A.
    - After the operation, `acc_b`=0.
    - If the result magnitude > 10**DIGITS−1, go to ERR. Otherwise go to the return target.
  - **S_RES** (result shown):
    - digit → `acc_a`=digit, `disp_neg`=0, next S_A.
    - op → chain on the result: `op_r`=op, next S_OP.
    - eq → ignored.
  - **ERR**: `err`=1. Only clear is accepted; all other events are ignored.
- Display selection:
  - `disp_val` = |`acc_a`| in S_A, S_OP, S_RES and S_CALC.
  - `disp_val` = `acc_b` in S_B.
  - `disp_val` = 0 in ERR.
- `disp_neg` = sign of `acc_a` when A is shown; 0 otherwise.
- Multiply intermediate width is 2W. Overflow is checked on the final product.

## Timing
- Reset values:
  - state S_A.
  - `disp_val`=0, `disp_neg`=0, `err`=0, `busy`=0.
- All outputs are registered or decoded from registered state. There is no combinational path from inputs to outputs.
- Digit, op and clear events are visible on the outputs in the cycle after the sampling edge.
- `busy` timing:
  - It rises in the cycle after the eq or op edge that enters S_CALC.
  - Add/sub: high for 1 cycle.
  - Mul: high for W cycles (14 at default).
- The result or `err` appears in the same cycle `busy` falls.
- A `press` while `busy`=1 is lost. It is not queued, including a clear.
- Reset asserted mid-multiply aborts immediately to the reset values.

## Structure
- `calc_pkg` holds:
  - State enum: S_A, S_OP, S_B, S_CALC, S_RES, S_ERR.
  - Op codes: OP_ADD, OP_SUB, OP_MUL, OP_CLR.
  - `DIGITS_MAX` constant.
- Sub-module `shift_add_mul`: start/done handshake, W-bit unsigned operands, 2W-bit product, W-cycle latency.
- Controller FSM, accumulators and display mux live in `calc_ctrl`.

## Test plan
- Reset low mid-run, then high → `disp_val`=0, `disp_neg`=0, `err`=0, `busy`=0, state S_A.
- Keys 1,2,+,3,4,= → `busy` high 1 cycle, then `disp_val`=46, `disp_neg`=0, S_RES.
- Keys 5,−,9,= → `disp_val`=4, `disp_neg`=1. Then +,2,= → `disp_val`=2, `disp_neg`=1.
- Keys 1,2,3,×,4,5,= → `busy` high 14 cycles, then `disp_val`=5535. A press during `busy` has no effect.
- Keys 9,9,9,9,× (op) 2,= → `err`=1, `disp_val`=0. Digits and `=` are then ignored. Clear → `err`=0, S_A.
- Digit limit and chaining:
  - Keys 1,2,3,4,5 → `disp_val`=1234 (fifth digit dropped).
  - Keys 7,+,3,+ → `disp_val`=10 after `busy`, S_OP.
  - Digit 11 via `num_val` → ignored.
